arb2to1: RTL and testbench
==========================

# arb2to1

Two-input round-robin stream arbiter that sits directly upstream of the mux2to1 select path. It decides which of two valid/ready sources, a or b, is forwarded each cycle. It registers the winning beat into a single output stage and publishes the winner on sel, so downstream logic can steer a 2:1 mux or tag the data. Fairness is strict alternation when both sources contend.

## Interface
Parameters:
- W, 8, data width of a_data, b_data, y_data.

Ports (clock and reset first):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  source a has a beat.
- a_data  input  W  source a payload.
- a_last  input  1  last beat of a packet from a; used only when ARB2_LOCK_EN is defined.
- a_ready  output  1  beat from a accepted this cycle (combinational).
- b_valid, b_data, b_last, b_ready: same as the a_* ports, for source b.
- y_valid  output  1  output register holds a beat.
- y_data  output  W  registered payload.
- y_last  output  1  registered last flag; tied 1 when the lock feature is compiled out.
- sel  output  1  registered source of the current y beat: 0 = a, 1 = b.
- y_ready  input  1  consumer accepts the y beat.

## Operation
- Output stage holds one beat.
- load = ~y_valid | y_ready; the stage may capture a new beat when it is empty or is being drained in the same cycle.
- Priority pointer prio (reset 0 = a preferred).
- Grant, combinational, when no lock is active:
  - only a_valid: grant a.
  - only b_valid: grant b.
  - both valid: grant the source named by prio.
  - neither valid: no grant.
- a_ready = load & grant_a; b_ready = load & grant_b. The two are never high together.
- On an accepted beat:
  - y_data, sel and y_last are loaded from the winner; y_valid is set to 1.
  - prio is set to the opposite of the winner.
- Drain without a new load (y_valid & y_ready & no grant): y_valid goes to 0. y_data and sel hold their last values.
- y_valid, y_data and sel change only on clk rising edges. Source data is never modified or merged.
- Reset, including mid-transfer: y_valid=0, y_data=0, sel=0, y_last=0, prio=0, lock cleared. Any in-flight beat is discarded. a_ready and b_ready are 0 while rst is high.

## Timing
- Latency: a beat accepted in cycle N appears on y_valid/y_data in cycle N+1.
- Full throughput: with y_ready held 1, one beat per cycle is sustained.
- Back-pressure: y_valid=1 & y_ready=0 forces a_ready=b_ready=0. y_data and sel are then held stable.
- Simultaneous drain and load in the same cycle: y_valid stays 1 and new data replaces old with no bubble.
- No combinational path from a_valid or b_valid to y_valid. The only combinational paths to a_ready/b_ready are from y_ready, y_valid, the *_valid inputs and internal state.

## Configuration
- Macro: ARB2_LOCK_EN.
- Defined:
  - A grant to source x with x_last=0 sets lock to x.
  - While locked, only x is eligible; the other source waits even if valid.
  - The lock clears on acceptance of x's beat with x_last=1.
  - prio updates only when the lock clears, i.e. at packet end.
  - y_last mirrors the winner's x_last.
- Undefined:
  - a_last and b_last are ignored and y_last is constant 1.
  - Arbitration is per beat.

## Test plan
- Reset mid-stream:
  - Stimulus: a_valid=1, y_ready=0, y_valid=1; assert rst.
  - Required: y_valid=0, sel=0, y_data=0 immediately (asynchronous). After release, the first contended grant goes to a.
- Contention alternation:
  - Stimulus: a_valid=b_valid=1 continuously, a_data=8'hA0+n, b_data=8'hB0+n, y_ready=1.
  - Required: y_data sequence A0,B0,A1,B1,...; sel toggles 0,1,0,1; one beat per cycle.
- Single source:
  - Stimulus: only b_valid=1 for 4 beats (8'h11..8'h14), y_ready=1.
  - Required: y_data 11,12,13,14 with sel=1 each cycle. a_ready stays 0 throughout.
- Back-pressure:
  - Stimulus: y_ready=0 for 3 cycles holding y_data=8'h5A.
  - Required: y_data stays 5A, a_ready=b_ready=0. When y_ready=1, the next beat loads with no gap.
- Drain to empty:
  - Stimulus: last beat consumed with no valid inputs.
  - Required: y_valid falls to 0 the next cycle; sel holds its last value.
- Lock (ARB2_LOCK_EN defined):
  - Stimulus: a sends 3 beats, last=0,0,1, while b_valid=1 throughout.
  - Required: y shows a,a,a (sel=0), then b. y_last=1 only on the third a beat.

Source files
------------

// File: rtl/arb2to1.sv
// arb2to1: two-source round-robin valid/ready arbiter with a registered output stage and winner select.
// Define ARB2_LOCK_EN to hold the grant for a whole packet, until a beat with *_last set is accepted.
module arb2to1 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  output logic         y_last,
  output logic         sel,
  input  logic         y_ready
);
  logic prio, load, va, vb, grant_a, grant_b, acc, win_last;
`ifdef ARB2_LOCK_EN
  logic lock, lock_src, last_r;
  assign va = a_valid & (~lock | ~lock_src);
  assign vb = b_valid & (~lock | lock_src);
  assign y_last = last_r;
`else
  logic unused_last;
  assign unused_last = a_last ^ b_last;
  assign va = a_valid;
  assign vb = b_valid;
  assign y_last = 1'b1;
`endif
  always_comb begin
    grant_a = va & (~vb | ~prio);
    grant_b = vb & (~va | prio);
    load = ~y_valid | y_ready;
    a_ready = ~rst & load & grant_a;
    b_ready = ~rst & load & grant_b;
    acc = a_ready | b_ready;
    win_last = grant_b ? b_last : a_last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data <= '0;
      sel <= 1'b0;
      prio <= 1'b0;
`ifdef ARB2_LOCK_EN
      lock <= 1'b0;
      lock_src <= 1'b0;
      last_r <= 1'b0;
`endif
    end else if (acc) begin
      y_valid <= 1'b1;
      y_data <= grant_b ? b_data : a_data;
      sel <= grant_b;
`ifdef ARB2_LOCK_EN
      last_r <= win_last;
      lock <= ~win_last;
      lock_src <= grant_b;
      if (win_last) prio <= ~grant_b;
`else
      prio <= ~grant_b;
`endif
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb2to1.sv
// tb_arb2to1: directed self-checking bench for arb2to1.
module tb_arb2to1;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, a_last = 1'b1, b_last = 1'b1, y_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0, y_data;
  logic a_ready, b_ready, y_valid, y_last, sel;
  int n_cmp = 0, n_bad = 0;
  int na, nb;
  arb2to1 #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .sel(sel), .y_ready(y_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    a_valid = 1'b1;
    #2;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_a_ready", a_ready, 0);
    tick;
    rst = 1'b0;
    a_data = 8'h33;
    tick;
    chk("mid_y_valid", y_valid, 1);
    chk("mid_y_data", y_data, 8'h33);
    chk("mid_bp_a_ready", a_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_y_valid", y_valid, 0);
    chk("async_y_data", y_data, 0);
    chk("async_sel", sel, 0);
    chk("async_a_ready", a_ready, 0);
    tick;
    rst = 1'b0;
    b_valid = 1'b1;
    y_ready = 1'b1;
    na = 0;
    nb = 0;
    for (int k = 0; k < 6; k++) begin
      a_data = 8'hA0 + 8'(na);
      b_data = 8'hB0 + 8'(nb);
      #1;
      chk("alt_a_ready", a_ready, (k % 2) == 0);
      chk("alt_b_ready", b_ready, (k % 2) == 1);
      tick;
      chk("alt_y_valid", y_valid, 1);
      chk("alt_y_data", y_data, (k % 2) == 0 ? 8'hA0 + na : 8'hB0 + nb);
      chk("alt_sel", sel, k % 2);
      chk("alt_y_last", y_last, 1);
      if (k % 2 == 0) na++; else nb++;
    end
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_data = 8'h11 + 8'(i);
      #1;
      chk("single_a_ready", a_ready, 0);
      tick;
      chk("single_y_data", y_data, 8'h11 + i);
      chk("single_sel", sel, 1);
    end
    a_valid = 1'b1;
    b_valid = 1'b0;
    a_data = 8'h5A;
    tick;
    chk("bp_load_y_data", y_data, 8'h5A);
    chk("bp_load_sel", sel, 0);
    y_ready = 1'b0;
    a_data = 8'h5B;
    b_valid = 1'b1;
    b_data = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_a_ready", a_ready, 0);
      chk("bp_b_ready", b_ready, 0);
      tick;
      chk("bp_y_data", y_data, 8'h5A);
      chk("bp_y_valid", y_valid, 1);
    end
    y_ready = 1'b1;
    #1;
    chk("bp_rel_b_ready", b_ready, 1);
    chk("bp_rel_a_ready", a_ready, 0);
    tick;
    chk("bp_rel_y_valid", y_valid, 1);
    chk("bp_rel_y_data", y_data, 8'hC0);
    chk("bp_rel_sel", sel, 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick;
    chk("drain_y_valid", y_valid, 0);
    chk("drain_sel", sel, 1);
    chk("drain_y_data", y_data, 8'hC0);
    tick;
    chk("empty_y_valid", y_valid, 0);
`ifdef ARB2_LOCK_EN
    a_valid = 1'b1;
    b_valid = 1'b1;
    b_data = 8'hBB;
    for (int i = 0; i < 4; i++) begin
      a_data = 8'h70 + 8'(i);
      a_last = (i == 2);
      tick;
      chk("lock_sel", sel, i == 3);
      chk("lock_y_data", y_data, i == 3 ? 8'hBB : 8'h70 + i);
      chk("lock_y_last", y_last, i >= 2);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
